// File: rtl/lamp_request_scheduler.sv
// Turn/hazard request scheduler for the tail lamp controller: 4-state Moore FSM plus lamp step prescaler.
// Optional macro TURN_AUTOCANCEL_EN enables auto-cancel of a turn after CANCEL_CNT lamp steps, with re-request lockout.
//
// state  | meaning
// IDLE   | no lamp activity, prescaler held at 0
// LEFT   | left turn signalling
// RIGHT  | right turn signalling
// HAZARD | hazard flashing, overrides everything
module lamp_request_scheduler #(
  parameter int DIV        = 4,
  parameter int CANCEL_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic       turn_left,
  output logic       turn_right,
  output logic       emergency,
  output logic       lamp_ce,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LEFT   = 2'b01,
    S_RIGHT  = 2'b10,
    S_HAZARD = 2'b11
  } state_t;

  localparam logic [7:0] PRESC_MAX = 8'(DIV - 1);
  localparam logic [7:0] STEP_LAST = 8'(CANCEL_CNT - 1);
`ifdef TURN_AUTOCANCEL_EN
  localparam bit AUTOCANCEL = 1'b1;
`else
  localparam bit AUTOCANCEL = 1'b0;
`endif

  state_t     cur_state;
  state_t     nxt_state;
  state_t     idle_next;
  logic [7:0] presc;
  logic [7:0] step_cnt;
  logic       lock_l;
  logic       lock_r;
  logic       state_change;
  logic       last_step;
  logic       cancel_l;
  logic       cancel_r;

  // A cancel fires on the edge that consumes the CANCEL_CNT-th lamp step while the turn is still requested.
  assign last_step    = lamp_ce && (step_cnt == STEP_LAST);
  assign cancel_l     = AUTOCANCEL && last_step && (cur_state == S_LEFT) && left_req && !hazard_req;
  assign cancel_r     = AUTOCANCEL && last_step && (cur_state == S_RIGHT) && right_req && !hazard_req;
  assign state_change = (nxt_state != cur_state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    idle_next = S_IDLE;
    if (left_req && !right_req && !lock_l) begin
      idle_next = S_LEFT;
    end else if (right_req && !left_req && !lock_r) begin
      idle_next = S_RIGHT;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    if (hazard_req) begin
      nxt_state = S_HAZARD;
    end else begin
      case (cur_state)
        S_IDLE, S_HAZARD: nxt_state = idle_next;
        S_LEFT: begin
          if (left_req) begin
            nxt_state = cancel_l ? S_IDLE : S_LEFT;
          end else begin
            nxt_state = (right_req && !lock_r) ? S_RIGHT : S_IDLE;
          end
        end
        S_RIGHT: begin
          if (right_req) begin
            nxt_state = cancel_r ? S_IDLE : S_RIGHT;
          end else begin
            nxt_state = (left_req && !lock_l) ? S_LEFT : S_IDLE;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    turn_left  = (cur_state == S_LEFT);
    turn_right = (cur_state == S_RIGHT);
    emergency  = (cur_state == S_HAZARD);
    lamp_ce    = (cur_state != S_IDLE) && (presc == PRESC_MAX);
    state      = cur_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= 8'd0;
    end else if (state_change || (cur_state == S_IDLE) || (presc == PRESC_MAX)) begin
      presc <= 8'd0;
    end else begin
      presc <= presc + 8'd1;
    end
  end

  // Saturating step counter; only turn states accumulate lamp steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= 8'd0;
    end else if (state_change) begin
      step_cnt <= 8'd0;
    end else if (lamp_ce && ((cur_state == S_LEFT) || (cur_state == S_RIGHT)) && (step_cnt != 8'hFF)) begin
      step_cnt <= step_cnt + 8'd1;
    end
  end

  // A lock holds off re-entry until the driver releases that request; release wins over set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_l <= 1'b0;
      lock_r <= 1'b0;
    end else begin
      if (!left_req) begin
        lock_l <= 1'b0;
      end else if (cancel_l) begin
        lock_l <= 1'b1;
      end
      if (!right_req) begin
        lock_r <= 1'b0;
      end else if (cancel_r) begin
        lock_r <= 1'b1;
      end
    end
  end

endmodule
